spi_controller: RTL and testbench

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_controller_if.sv | 28 ++
 rtl/spi_controller.sv | 136 +++++++++++++
 tb/tb_spi_controller.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_controller_if.sv
// Datapath-facing side of the SPI controller: TX/RX FIFO strobes plus the
// internal SPI clock and half-period count that the shift register follows.
interface spi_controller_if;
    logic        tx_fifo_empty;
    logic        tx_fifo_read;
    logic        rx_fifo_write;
    logic        xfer_done;
    logic        spi_clk_o;
    logic [11:0] clock_cnt;

    modport master (
        input  tx_fifo_empty,
        output tx_fifo_read,
        output rx_fifo_write,
        output xfer_done,
        output spi_clk_o,
        output clock_cnt
    );

    modport slave (
        output tx_fifo_empty,
        input  tx_fifo_read,
        input  rx_fifo_write,
        input  xfer_done,
        input  spi_clk_o,
        input  clock_cnt
    );
endinterface

// File: rtl/spi_controller.sv
// SPI master sequencer: chip-select setup, 16 half-period SCLK toggles per byte, FIFO strobes.
// Optional feature: define SPI_BURST_EN to chain queued bytes with cs_n held low.
module spi_controller (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spi_en,
    input  logic                spi_clk_pol,
    input  logic [11:0]         spi_clk_period,
    spi_controller_if.master    dp,
    output logic                sclk,
    output logic                cs_n,
    output logic [2:0]          state_ff,
    output logic [2:0]          state_next,
    output logic                spi_busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        TRANS = 3'd2,
        DONE  = 3'd3
    } type_spi_states_e;

    localparam logic [4:0] LAST_EDGE = 5'd15;

    type_spi_states_e cur_st;
    type_spi_states_e nxt_st;

    logic [11:0] cnt_q;
    logic [11:0] cnt_d;
    logic [4:0]  edge_q;
    logic [4:0]  edge_d;
    logic        sck_q;
    logic        sck_d;
    logic        half_done;
    logic        chain_ok;

    assign half_done = (cnt_q == spi_clk_period);

`ifdef SPI_BURST_EN
    assign chain_ok = spi_en & ~dp.tx_fifo_empty;
`else
    // Without burst support every byte gets its own chip-select frame.
    assign chain_ok = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_st <= IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            IDLE: begin
                if (spi_en && !dp.tx_fifo_empty) begin
                    nxt_st = WAIT;
                end
            end
            WAIT: begin
                if (half_done) begin
                    nxt_st = TRANS;
                end
            end
            TRANS: begin
                if (half_done && (edge_q == LAST_EDGE)) begin
                    nxt_st = DONE;
                end
            end
            DONE: begin
                nxt_st = chain_ok ? WAIT : IDLE;
            end
            default: begin
                nxt_st = IDLE;
            end
        endcase
    end

    // Counters and SCLK restart from zero on every state change; the 16th
    // toggle coincides with leaving TRANS, so SCLK lands back at 0 there.
    always_comb begin
        cnt_d  = '0;
        edge_d = '0;
        sck_d  = 1'b0;
        if (nxt_st == cur_st) begin
            case (cur_st)
                WAIT: begin
                    cnt_d = cnt_q + 12'd1;
                end
                TRANS: begin
                    if (half_done) begin
                        cnt_d  = '0;
                        edge_d = edge_q + 5'd1;
                        sck_d  = ~sck_q;
                    end else begin
                        cnt_d  = cnt_q + 12'd1;
                        edge_d = edge_q;
                        sck_d  = sck_q;
                    end
                end
                default: begin
                    cnt_d  = '0;
                    edge_d = '0;
                    sck_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            edge_q <= '0;
            sck_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            edge_q <= edge_d;
            sck_q  <= sck_d;
        end
    end

    assign state_ff         = cur_st;
    assign state_next       = nxt_st;
    assign spi_busy         = (cur_st != IDLE);
    assign cs_n             = (cur_st == IDLE);
    assign dp.tx_fifo_read  = (cur_st == WAIT) && (nxt_st == TRANS);
    assign dp.rx_fifo_write = (cur_st == DONE);
    assign dp.xfer_done     = (cur_st == DONE);
    assign dp.spi_clk_o     = sck_q;
    assign dp.clock_cnt     = cnt_q;
    assign sclk             = sck_q ^ spi_clk_pol;

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: directed scenarios plus randomized
// transfers compared against a cycle timeline built from the byte-framing rules.
`timescale 1ns/1ps
module tb_spi_controller;

    localparam int MAXT = 1024;
`ifdef SPI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_en;
    logic        spi_clk_pol;
    logic [11:0] spi_clk_period;
    logic        sclk;
    logic        cs_n;
    logic [2:0]  state_ff;
    logic [2:0]  state_next;
    logic        spi_busy;

    int tx_q;
    int drop_toggle;
    int checks;
    int errors;

    spi_controller_if ifc();
    assign ifc.tx_fifo_empty = (tx_q == 0);

    spi_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .spi_en         (spi_en),
        .spi_clk_pol    (spi_clk_pol),
        .spi_clk_period (spi_clk_period),
        .dp             (ifc),
        .sclk           (sclk),
        .cs_n           (cs_n),
        .state_ff       (state_ff),
        .state_next     (state_next),
        .spi_busy       (spi_busy)
    );

    always #5 clk = ~clk;

    // Observed trace, one entry per clock, sampled on the falling edge.
    logic [2:0]  tr_st   [MAXT];
    logic [2:0]  tr_nx   [MAXT];
    logic [11:0] tr_cnt  [MAXT];
    logic        tr_clk  [MAXT];
    logic        tr_sclk [MAXT];
    logic        tr_csn  [MAXT];
    logic        tr_txr  [MAXT];
    logic        tr_rxw  [MAXT];
    logic        tr_xd   [MAXT];
    logic        tr_busy [MAXT];

    // Expected timeline: 0 idle, 1 cs setup, 2 shifting, 3 byte done.
    int   ex_st  [MAXT];
    int   ex_cnt [MAXT];
    logic ex_clk [MAXT];
    logic ex_txr [MAXT];
    logic ex_rxw [MAXT];

    function automatic void build_model(input int p, input int nb, input bit burst, input int len);
        int t;
        int h;
        h = p + 1;
        for (int i = 0; i < len; i++) begin
            ex_st[i] = 0; ex_cnt[i] = 0; ex_clk[i] = 1'b0; ex_txr[i] = 1'b0; ex_rxw[i] = 1'b0;
        end
        t = 0;
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < h; k++) begin
                if (t < len) begin ex_st[t] = 1; ex_cnt[t] = k; ex_txr[t] = (k == h - 1); end
                t++;
            end
            for (int k = 0; k < 16 * h; k++) begin
                if (t < len) begin ex_st[t] = 2; ex_cnt[t] = k % h; ex_clk[t] = (((k / h) % 2) == 1); end
                t++;
            end
            if (t < len) begin ex_st[t] = 3; ex_rxw[t] = 1'b1; end
            t++;
            if (!burst) t++;
        end
    endfunction

    task automatic record(input int n);
        int   tg;
        logic prev;
        tg   = 0;
        prev = ifc.spi_clk_o;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tr_st[i] = state_ff;       tr_nx[i] = state_next;    tr_cnt[i] = ifc.clock_cnt;
            tr_clk[i] = ifc.spi_clk_o; tr_sclk[i] = sclk;        tr_csn[i] = cs_n;
            tr_txr[i] = ifc.tx_fifo_read; tr_rxw[i] = ifc.rx_fifo_write;
            tr_xd[i] = ifc.xfer_done;  tr_busy[i] = spi_busy;
            if (ifc.spi_clk_o !== prev) tg++;
            prev = ifc.spi_clk_o;
            if (ifc.tx_fifo_read === 1'b1 && tx_q > 0) tx_q--;
            if (drop_toggle > 0 && tg == drop_toggle) spi_en = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; spi_en = 1'b1; tx_q = 1; spi_clk_pol = 1'b1; spi_clk_period = 12'd2;
        repeat (3) @(negedge clk);
        checks++; if (state_ff !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state_ff); end
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n got %b exp 1", cs_n); end
        checks++; if (ifc.spi_clk_o !== 1'b0) begin errors++; $display("FAIL rst_spi_clk got %b exp 0", ifc.spi_clk_o); end
        checks++; if (ifc.clock_cnt !== 12'd0) begin errors++; $display("FAIL rst_clock_cnt got %0d exp 0", ifc.clock_cnt); end
        checks++; if (ifc.tx_fifo_read !== 1'b0) begin errors++; $display("FAIL rst_tx_read got %b exp 0", ifc.tx_fifo_read); end
        checks++; if (ifc.rx_fifo_write !== 1'b0) begin errors++; $display("FAIL rst_rx_write got %b exp 0", ifc.rx_fifo_write); end
        checks++; if (ifc.xfer_done !== 1'b0) begin errors++; $display("FAIL rst_xfer_done got %b exp 0", ifc.xfer_done); end
        checks++; if (spi_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", spi_busy); end
        checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL rst_sclk_pol1 got %b exp 1", sclk); end
        spi_clk_pol = 1'b0;
        #1;
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk_pol0 got %b exp 0", sclk); end
        spi_en = 1'b0; tx_q = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (state_ff !== 3'd0) begin errors++; $display("FAIL post_rst_state got %0d exp 0", state_ff); end
    endtask

    task automatic test_single_byte();
        int p;
        int len;
        int tx_idx;
        int ntog;
        int last_tog;
        int nrx;
        int nxd;
        int nlow;
        int rx_idx;
        p = 3; len = 17 * (p + 1) + 6;
        spi_clk_period = 12'(p); spi_clk_pol = 1'b0;
        tx_q = 1; spi_en = 1'b1;
        record(len);
        spi_en = 1'b0;
        tx_idx = -1; ntog = 0; last_tog = -1; nrx = 0; nxd = 0; nlow = 0; rx_idx = -1;
        for (int i = 0; i < len; i++) begin
            if (tr_txr[i] === 1'b1 && tx_idx < 0) tx_idx = i;
            if (tr_rxw[i] === 1'b1) begin nrx++; rx_idx = i; end
            if (tr_xd[i] === 1'b1) nxd++;
            if (tr_csn[i] === 1'b0) nlow++;
            if (i > 0 && tr_clk[i] !== tr_clk[i-1]) begin
                if (ntog == 0) begin
                    checks++;
                    if (i != tx_idx + 1 + (p + 1)) begin errors++; $display("FAIL single_first_toggle got %0d exp %0d", i, tx_idx + 2 + p); end
                end else begin
                    checks++;
                    if (i - last_tog != p + 1) begin errors++; $display("FAIL single_toggle_gap got %0d exp %0d", i - last_tog, p + 1); end
                end
                ntog++; last_tog = i;
            end
        end
        checks++; if (tx_idx != p) begin errors++; $display("FAIL single_cs_setup got %0d exp %0d", tx_idx + 1, p + 1); end
        checks++; if (ntog != 16) begin errors++; $display("FAIL single_toggles got %0d exp 16", ntog); end
        checks++; if (nrx != 1) begin errors++; $display("FAIL single_rx_pulses got %0d exp 1", nrx); end
        checks++; if (nxd != 1) begin errors++; $display("FAIL single_done_pulses got %0d exp 1", nxd); end
        checks++; if (rx_idx != 17 * (p + 1)) begin errors++; $display("FAIL single_rx_cycle got %0d exp %0d", rx_idx, 17 * (p + 1)); end
        checks++; if (nlow != 17 * (p + 1) + 1) begin errors++; $display("FAIL single_cs_low got %0d exp %0d", nlow, 17 * (p + 1) + 1); end
        checks++; if (tr_csn[len-1] !== 1'b1) begin errors++; $display("FAIL single_cs_end got %b exp 1", tr_csn[len-1]); end
        checks++; if (tx_q != 0) begin errors++; $display("FAIL single_tx_pop got %0d exp 0", tx_q); end
    endtask

    task automatic test_fast_cpol();
        int nsw;
        spi_clk_period = 12'd0; spi_clk_pol = 1'b1;
        @(negedge clk);
        checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL cpol_idle got %b exp 1", sclk); end
        tx_q = 1; spi_en = 1'b1;
        record(22);
        spi_en = 1'b0;
        nsw = 0;
        for (int i = 2; i <= 17; i++) begin
            checks++;
            if (tr_sclk[i] === tr_sclk[i-1]) begin errors++; $display("FAIL cpol_toggle cyc=%0d got %b exp %b", i, tr_sclk[i], ~tr_sclk[i-1]); end
            else nsw++;
        end
        checks++; if (tr_sclk[1] !== 1'b1) begin errors++; $display("FAIL cpol_trans_start got %b exp 1", tr_sclk[1]); end
        checks++; if (tr_st[17] !== 3'd3) begin errors++; $display("FAIL cpol_done_cycle got %0d exp 3", tr_st[17]); end
        checks++; if (tr_rxw[17] !== 1'b1) begin errors++; $display("FAIL cpol_rx_write got %b exp 1", tr_rxw[17]); end
        checks++; if (tr_sclk[21] !== 1'b1) begin errors++; $display("FAIL cpol_final_idle got %b exp 1", tr_sclk[21]); end
        checks++; if (nsw != 16) begin errors++; $display("FAIL cpol_toggle_count got %0d exp 16", nsw); end
        spi_clk_pol = 1'b0;
    endtask

    task automatic test_back_to_back();
        int p;
        int len;
        int nrx;
        int ntx;
        int r1;
        int r2;
        int gap;
        p = int'($urandom_range(2, 0));
        len = 2 * (17 * (p + 1) + 2) + 4;
        spi_clk_period = 12'(p);
        tx_q = 2; spi_en = 1'b1;
        record(len);
        spi_en = 1'b0;
        nrx = 0; ntx = 0; r1 = -1; r2 = -1; gap = 0;
        for (int i = 0; i < len; i++) begin
            if (tr_txr[i] === 1'b1) ntx++;
            if (tr_rxw[i] === 1'b1) begin
                nrx++;
                if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i;
            end
        end
        if (r1 >= 0 && r2 > r1) begin
            for (int i = r1 + 1; i < r2; i++) if (tr_csn[i] === 1'b1) gap++;
        end
        checks++; if (nrx != 2) begin errors++; $display("FAIL b2b_rx_pulses got %0d exp 2", nrx); end
        checks++; if (ntx != 2) begin errors++; $display("FAIL b2b_tx_reads got %0d exp 2", ntx); end
        checks++; if (gap != (BURST ? 0 : 1)) begin errors++; $display("FAIL b2b_cs_gap got %0d exp %0d", gap, BURST ? 0 : 1); end
        checks++; if (tx_q != 0) begin errors++; $display("FAIL b2b_queue got %0d exp 0", tx_q); end
    endtask

    task automatic test_en_drop();
        int p;
        int len;
        int ntog;
        int nrx;
        p = int'($urandom_range(3, 0));
        len = 2 * (17 * (p + 1) + 2) + 4;
        spi_clk_period = 12'(p);
        tx_q = 2; drop_toggle = 5; spi_en = 1'b1;
        record(len);
        drop_toggle = -1; spi_en = 1'b0;
        ntog = 0; nrx = 0;
        for (int i = 0; i < len; i++) begin
            if (i > 0 && tr_clk[i] !== tr_clk[i-1]) ntog++;
            if (tr_rxw[i] === 1'b1) nrx++;
        end
        checks++; if (ntog != 16) begin errors++; $display("FAIL endrop_toggles got %0d exp 16", ntog); end
        checks++; if (nrx != 1) begin errors++; $display("FAIL endrop_rx_pulses got %0d exp 1", nrx); end
        checks++; if (tr_st[len-1] !== 3'd0) begin errors++; $display("FAIL endrop_final_state got %0d exp 0", tr_st[len-1]); end
        checks++; if (tx_q != 1) begin errors++; $display("FAIL endrop_queue got %0d exp 1", tx_q); end
        tx_q = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int   tg;
        int   nrx;
        bit   hit;
        logic prev;
        spi_clk_period = 12'(int'($urandom_range(3, 1)));
        tx_q = 1; spi_en = 1'b1;
        tg = 0; nrx = 0; hit = 1'b0; prev = ifc.spi_clk_o;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            if (ifc.rx_fifo_write === 1'b1) nrx++;
            if (ifc.tx_fifo_read === 1'b1 && tx_q > 0) tx_q--;
            if (ifc.spi_clk_o !== prev) tg++;
            prev = ifc.spi_clk_o;
            if (tg == 9) hit = 1'b1;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL rstmid_reach_toggle9 got %0d exp 9", tg); end
        rst_n = 1'b0;
        #1;
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL rstmid_cs_n got %b exp 1", cs_n); end
        checks++; if (ifc.spi_clk_o !== 1'b0) begin errors++; $display("FAIL rstmid_spi_clk got %b exp 0", ifc.spi_clk_o); end
        checks++; if (state_ff !== 3'd0) begin errors++; $display("FAIL rstmid_state got %0d exp 0", state_ff); end
        checks++; if (ifc.clock_cnt !== 12'd0) begin errors++; $display("FAIL rstmid_clock_cnt got %0d exp 0", ifc.clock_cnt); end
        spi_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ifc.rx_fifo_write === 1'b1) nrx++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ifc.rx_fifo_write === 1'b1) nrx++;
        end
        checks++; if (nrx != 0) begin errors++; $display("FAIL rstmid_rx_pulses got %0d exp 0", nrx); end
        checks++; if (state_ff !== 3'd0) begin errors++; $display("FAIL rstmid_after_state got %0d exp 0", state_ff); end
        tx_q = 0;
    endtask

    task automatic test_empty_idle();
        tx_q = 0; spi_en = 1'b1;
        record(20);
        spi_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            checks++; if (tr_st[i] !== 3'd0) begin errors++; $display("FAIL empty_state cyc=%0d got %0d exp 0", i, tr_st[i]); end
            checks++; if (tr_txr[i] !== 1'b0) begin errors++; $display("FAIL empty_tx_read cyc=%0d got %b exp 0", i, tr_txr[i]); end
        end
    endtask

    task automatic test_random_transfers(input int iters);
        for (int it = 0; it < iters; it++) begin
            int p;
            int nb;
            int len;
            p  = int'($urandom_range(6, 0));
            nb = int'($urandom_range(3, 1));
            spi_clk_pol    = 1'($urandom_range(1, 0));
            spi_clk_period = 12'(p);
            len = nb * (17 * (p + 1) + 2) + 4;
            build_model(p, nb, BURST, len);
            @(negedge clk);
            tx_q = nb; spi_en = 1'b1;
            record(len);
            spi_en = 1'b0;
            for (int i = 0; i < len; i++) begin
                checks++; if (tr_st[i] !== 3'(ex_st[i])) begin errors++; $display("FAIL rnd_state it=%0d cyc=%0d got %0d exp %0d", it, i, tr_st[i], ex_st[i]); end
                if (i < len - 1) begin
                    checks++; if (tr_nx[i] !== 3'(ex_st[i+1])) begin errors++; $display("FAIL rnd_next it=%0d cyc=%0d got %0d exp %0d", it, i, tr_nx[i], ex_st[i+1]); end
                end
                checks++; if (tr_cnt[i] !== 12'(ex_cnt[i])) begin errors++; $display("FAIL rnd_clock_cnt it=%0d cyc=%0d got %0d exp %0d", it, i, tr_cnt[i], ex_cnt[i]); end
                checks++; if (tr_clk[i] !== ex_clk[i]) begin errors++; $display("FAIL rnd_spi_clk it=%0d cyc=%0d got %b exp %b", it, i, tr_clk[i], ex_clk[i]); end
                checks++; if (tr_sclk[i] !== (ex_clk[i] ^ spi_clk_pol)) begin errors++; $display("FAIL rnd_sclk it=%0d cyc=%0d got %b exp %b", it, i, tr_sclk[i], ex_clk[i] ^ spi_clk_pol); end
                checks++; if (tr_csn[i] !== (ex_st[i] == 0)) begin errors++; $display("FAIL rnd_cs_n it=%0d cyc=%0d got %b exp %b", it, i, tr_csn[i], ex_st[i] == 0); end
                checks++; if (tr_busy[i] !== (ex_st[i] != 0)) begin errors++; $display("FAIL rnd_busy it=%0d cyc=%0d got %b exp %b", it, i, tr_busy[i], ex_st[i] != 0); end
                checks++; if (tr_txr[i] !== ex_txr[i]) begin errors++; $display("FAIL rnd_tx_read it=%0d cyc=%0d got %b exp %b", it, i, tr_txr[i], ex_txr[i]); end
                checks++; if (tr_rxw[i] !== ex_rxw[i]) begin errors++; $display("FAIL rnd_rx_write it=%0d cyc=%0d got %b exp %b", it, i, tr_rxw[i], ex_rxw[i]); end
                checks++; if (tr_xd[i] !== ex_rxw[i]) begin errors++; $display("FAIL rnd_xfer_done it=%0d cyc=%0d got %b exp %b", it, i, tr_xd[i], ex_rxw[i]); end
            end
            checks++; if (tx_q != 0) begin errors++; $display("FAIL rnd_queue it=%0d got %0d exp 0", it, tx_q); end
        end
    endtask

    initial begin
        checks = 0; errors = 0; drop_toggle = -1;
        rst_n = 1'b0; spi_en = 1'b0; spi_clk_pol = 1'b0; spi_clk_period = 12'd0; tx_q = 0;
        test_reset();
        test_single_byte();
        test_fast_cpol();
        test_back_to_back();
        test_en_drop();
        test_reset_mid();
        test_empty_idle();
        test_random_transfers(6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
